iq_alloc: RTL and testbench

- Allocation unit for the 16-entry centralized issue queue (CIQ).
- Each cycle it hands up to DECODE_NUM free CIQ entry addresses (`free_addr`/`free_valid`) to the renamed instructions being dispatched.
- It tracks entry occupancy in a registered bitmap and releases an entry when the arbiter grants (issues) it.
- It sits between rename/dispatch and the CIQ write port; it is the producer side of the CIQ allocation interface.

---
 rtl/iq_alloc.sv | 69 ++++++
 tb/tb_iq_alloc.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/iq_alloc.sv
// iq_alloc: hands out the lowest-indexed free CIQ entries to dispatch slots and frees entries on issue grants
//   clk, rst_n (async, active-low)
//   alloc_req   : per-slot allocation request
//   flush       : empties the occupancy map
//   arbit_addr  : granted entry address per issue port
//   arbit_grant : per-port issue valid
//   free_addr   : allocated entry per slot (0 when not allocated)
//   free_valid  : per-slot allocation valid
//   alloc_stall : requests present but cannot all be satisfied
//   free_count  : number of unoccupied entries
module iq_alloc #(
  parameter int DECODE_NUM = 4,
  parameter int ISSUE_NUM  = 4,
  parameter int CIQ_DEPTH  = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DECODE_NUM-1:0]            alloc_req,
  input  logic                             flush,
  input  logic [ISSUE_NUM*ADDR_WIDTH-1:0]  arbit_addr,
  input  logic [ISSUE_NUM-1:0]             arbit_grant,
  output logic [DECODE_NUM*ADDR_WIDTH-1:0] free_addr,
  output logic [DECODE_NUM-1:0]            free_valid,
  output logic                             alloc_stall,
  output logic [ADDR_WIDTH:0]              free_count
);
  localparam logic [ADDR_WIDTH:0] ONE = 1;
  logic [CIQ_DEPTH-1:0] occ, rel, alloc;
  logic [ADDR_WIDTH:0] need, cnt, k;
  logic ok;
  always_comb begin
    free_count = '0;
    need = '0;
    for (int e = 0; e < CIQ_DEPTH; e++) free_count = free_count + {{ADDR_WIDTH{1'b0}}, ~occ[e]};
    for (int i = 0; i < DECODE_NUM; i++) need = need + {{ADDR_WIDTH{1'b0}}, alloc_req[i]};
    ok = (need <= free_count) && !flush;
    alloc_stall = (need != '0) && !ok;
    free_valid = ok ? alloc_req : '0;
    free_addr = '0;
    alloc = '0;
    k = '0;
    cnt = '0;
    // slot i takes the k-th free entry, k = number of requesting slots below i
    for (int i = 0; i < DECODE_NUM; i++) begin
      if (free_valid[i]) begin
        cnt = '0;
        for (int e = 0; e < CIQ_DEPTH; e++) begin
          if (!occ[e]) begin
            if (cnt == k) begin
              free_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(e);
              alloc[e] = 1'b1;
            end
            cnt = cnt + ONE;
          end
        end
        k = k + ONE;
      end
    end
    rel = '0;
    for (int j = 0; j < ISSUE_NUM; j++)
      if (arbit_grant[j]) rel[arbit_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ <= '0;
    else if (flush) occ <= '0;
    else occ <= (occ & ~rel) | alloc;
  end
endmodule

// File: tb/tb_iq_alloc.sv
// tb_iq_alloc: scoreboard-driven directed and random checks of iq_alloc
module tb_iq_alloc;
  logic clk = 0, rst_n = 0, flush = 0;
  logic [3:0] alloc_req = 0, arbit_grant = 0;
  logic [15:0] arbit_addr = 0;
  logic [15:0] free_addr;
  logic [3:0] free_valid;
  logic alloc_stall;
  logic [4:0] free_count;
  int checks = 0, failures = 0;
  typedef struct packed {logic [3:0] v; logic [15:0] a; logic s;} exp_t;
  exp_t q[$];

  iq_alloc dut (.clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .flush(flush),
    .arbit_addr(arbit_addr), .arbit_grant(arbit_grant), .free_addr(free_addr),
    .free_valid(free_valid), .alloc_stall(alloc_stall), .free_count(free_count));

  always #5 clk = ~clk;

  task automatic tick; @(posedge clk); #1; endtask

  task automatic set_in(input logic [3:0] r, input logic [3:0] g, input logic [15:0] ga, input logic f);
    alloc_req = r; arbit_grant = g; arbit_addr = ga; flush = f;
  endtask

  task automatic test_reset;
    exp_t e;
    q.push_back({4'b0, 16'h0, 1'b0});
    #3;
    e = q.pop_front(); checks++;
    if ({free_valid, free_addr, alloc_stall} !== e) begin failures++;
      $display("FAIL reset_out got=%h exp=%h", {free_valid, free_addr, alloc_stall}, e); end
    checks++;
    if (free_count !== 5'd16) begin failures++; $display("FAIL reset_count got=%0d exp=16", free_count); end
    @(negedge clk); rst_n = 1;
    tick;
  endtask

  task automatic test_all_slots;
    exp_t e;
    set_in(4'b1111, 0, 0, 0); q.push_back({4'b1111, 16'h3210, 1'b0}); #2;
    e = q.pop_front(); checks++;
    if ({free_valid, free_addr, alloc_stall} !== e) begin failures++;
      $display("FAIL all_slots got=%h exp=%h", {free_valid, free_addr, alloc_stall}, e); end
    tick; set_in(0, 0, 0, 0); #1; checks++;
    if (free_count !== 5'd12) begin failures++; $display("FAIL all_slots_count got=%0d exp=12", free_count); end
    set_in(0, 0, 0, 1); tick; set_in(0, 0, 0, 0); #1; checks++;
    if (free_count !== 5'd16) begin failures++; $display("FAIL flush_empty got=%0d exp=16", free_count); end
  endtask

  task automatic test_sparse_and_fill;
    exp_t e;
    set_in(4'b1010, 0, 0, 0); q.push_back({4'b1010, 16'h1000, 1'b0}); #1;
    e = q.pop_front(); checks++;
    if ({free_valid, free_addr, alloc_stall} !== e) begin failures++;
      $display("FAIL sparse got=%h exp=%h", {free_valid, free_addr, alloc_stall}, e); end
    tick; set_in(0, 0, 0, 0); #1; checks++;
    if (free_count !== 5'd14) begin failures++; $display("FAIL sparse_count got=%0d exp=14", free_count); end
    set_in(4'b1111, 0, 0, 0);
    q.push_back({4'b1111, 16'h5432, 1'b0});
    q.push_back({4'b1111, 16'h9876, 1'b0});
    q.push_back({4'b1111, 16'hDCBA, 1'b0});
    for (int n = 0; n < 3; n++) begin
      #1; e = q.pop_front(); checks++;
      if ({free_valid, free_addr, alloc_stall} !== e) begin failures++;
        $display("FAIL fill%0d got=%h exp=%h", n, {free_valid, free_addr, alloc_stall}, e); end
      tick;
    end
    set_in(4'b0011, 0, 0, 0); q.push_back({4'b0011, 16'h00FE, 1'b0}); #1;
    e = q.pop_front(); checks++;
    if ({free_valid, free_addr, alloc_stall} !== e) begin failures++;
      $display("FAIL fill_last got=%h exp=%h", {free_valid, free_addr, alloc_stall}, e); end
    tick; set_in(0, 0, 0, 0); #1; checks++;
    if (free_count !== 5'd0) begin failures++; $display("FAIL full_count got=%0d exp=0", free_count); end
  endtask

  task automatic test_full_release;
    exp_t e;
    set_in(4'b0001, 4'b0001, 16'h0005, 0); q.push_back({4'b0, 16'h0, 1'b1}); #1;
    e = q.pop_front(); checks++;
    if ({free_valid, free_addr, alloc_stall} !== e) begin failures++;
      $display("FAIL release_same_cycle got=%h exp=%h", {free_valid, free_addr, alloc_stall}, e); end
    checks++;
    if (free_count !== 5'd0) begin failures++; $display("FAIL release_latency got=%0d exp=0", free_count); end
    tick; set_in(4'b0001, 0, 0, 0); q.push_back({4'b0001, 16'h0005, 1'b0}); #1;
    e = q.pop_front(); checks++;
    if ({free_valid, free_addr, alloc_stall} !== e) begin failures++;
      $display("FAIL release_next got=%h exp=%h", {free_valid, free_addr, alloc_stall}, e); end
    tick; set_in(0, 0, 0, 0);
  endtask

  task automatic test_partial_stall;
    exp_t e;
    set_in(0, 4'b0011, 16'h0097, 0); tick; set_in(0, 0, 0, 0); #1; checks++;
    if (free_count !== 5'd2) begin failures++; $display("FAIL two_free_count got=%0d exp=2", free_count); end
    set_in(4'b0111, 0, 0, 0); q.push_back({4'b0, 16'h0, 1'b1}); #1;
    e = q.pop_front(); checks++;
    if ({free_valid, free_addr, alloc_stall} !== e) begin failures++;
      $display("FAIL partial_stall got=%h exp=%h", {free_valid, free_addr, alloc_stall}, e); end
    tick; #1; checks++;
    if (free_count !== 5'd2) begin failures++; $display("FAIL stall_no_alloc got=%0d exp=2", free_count); end
    set_in(4'b0011, 0, 0, 0); q.push_back({4'b0011, 16'h0097, 1'b0}); #1;
    e = q.pop_front(); checks++;
    if ({free_valid, free_addr, alloc_stall} !== e) begin failures++;
      $display("FAIL partial_retry got=%h exp=%h", {free_valid, free_addr, alloc_stall}, e); end
    tick; set_in(0, 0, 0, 0);
  endtask

  task automatic test_dup_grant;
    set_in(0, 4'b0001, 16'h000C, 0); tick; set_in(0, 0, 0, 0); #1; checks++;
    if (free_count !== 5'd1) begin failures++; $display("FAIL pre_dup_count got=%0d exp=1", free_count); end
    set_in(0, 4'b0111, 16'h0C33, 0); tick; set_in(0, 0, 0, 0); #1; checks++;
    if (free_count !== 5'd2) begin failures++; $display("FAIL dup_grant_count got=%0d exp=2", free_count); end
  endtask

  task automatic test_flush;
    exp_t e;
    set_in(4'b1111, 4'b0001, 16'h0001, 1); q.push_back({4'b0, 16'h0, 1'b1}); #1;
    e = q.pop_front(); checks++;
    if ({free_valid, free_addr, alloc_stall} !== e) begin failures++;
      $display("FAIL flush_stall got=%h exp=%h", {free_valid, free_addr, alloc_stall}, e); end
    tick; set_in(0, 0, 0, 0); #1; checks++;
    if (free_count !== 5'd16) begin failures++; $display("FAIL flush_count got=%0d exp=16", free_count); end
  endtask

  task automatic test_async_reset;
    set_in(4'b1111, 0, 0, 0); tick; set_in(0, 0, 0, 0); #1; checks++;
    if (free_count !== 5'd12) begin failures++; $display("FAIL pre_rst_count got=%0d exp=12", free_count); end
    rst_n = 0; #1; checks++;
    if (free_count !== 5'd16) begin failures++; $display("FAIL async_rst_count got=%0d exp=16", free_count); end
    #1; rst_n = 1;
    tick;
  endtask

  task automatic test_random;
    logic [15:0] mocc, tmp, rel;
    logic [15:0] ea;
    logic [3:0] r, g;
    logic [15:0] ga;
    logic f, ok;
    int e_idx, nd;
    exp_t e;
    mocc = '0;
    for (int n = 0; n < 300; n++) begin
      r = 4'($urandom); g = 4'($urandom); ga = 16'($urandom); f = ($urandom_range(0, 15) == 0);
      set_in(r, g, ga, f);
      nd = $countones(r);
      ok = (nd <= 16 - $countones(mocc)) && !f;
      tmp = mocc; ea = '0;
      if (ok)
        for (int i = 0; i < 4; i++)
          if (r[i]) begin
            e_idx = 0;
            while (tmp[e_idx]) e_idx++;
            tmp[e_idx] = 1'b1;
            ea[i*4 +: 4] = 4'(e_idx);
          end
      q.push_back({ok ? r : 4'b0, ea, (nd != 0) && !ok});
      #1;
      e = q.pop_front(); checks++;
      if ({free_valid, free_addr, alloc_stall} !== e) begin failures++;
        $display("FAIL rand_out n=%0d got=%h exp=%h", n, {free_valid, free_addr, alloc_stall}, e); end
      checks++;
      if (free_count !== 5'(16 - $countones(mocc))) begin failures++;
        $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, free_count, 16 - $countones(mocc)); end
      rel = '0;
      for (int j = 0; j < 4; j++) if (g[j]) rel[ga[j*4 +: 4]] = 1'b1;
      mocc = f ? 16'h0 : ((mocc & ~rel) | (tmp & ~mocc));
      tick;
    end
    set_in(0, 0, 0, 0);
  endtask

  initial begin
    test_reset;
    test_all_slots;
    test_sparse_and_fill;
    test_full_release;
    test_partial_stall;
    test_dup_grant;
    test_flush;
    test_async_reset;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
